// File: rtl/rs_dispatch_queue_pkg.sv
// Shared definitions for the reservation-station dispatch queue.
// Holds the opcode encodings the queue decodes, the default field widths,
// the RS entry record and small opcode classification helpers.
// The entry record uses the package widths. The top-level parameters
// default to these widths, so instantiate the top at those widths.
package rs_dispatch_queue_pkg;

   localparam int RS_PREG_W = 6;
   localparam int RS_ROB_W  = 4;
   localparam int RS_XLEN   = 32;
   localparam int RS_NUM_FU = 3;
   localparam int RS_FU_W   = 2;

   // The highest-numbered FU is the memory unit.
   localparam int MEM_FU = RS_NUM_FU - 1;

   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef struct packed {
      logic                  valid;
      logic [6:0]            op;
      logic [RS_FU_W-1:0]    fu;
      logic [RS_PREG_W-1:0]  pd;
      logic [RS_ROB_W-1:0]   rob;
      logic [RS_PREG_W-1:0]  s1_tag;
      logic                  s1_rdy;
      logic [RS_XLEN-1:0]    s1_data;
      logic [RS_PREG_W-1:0]  s2_tag;
      logic                  s2_rdy;
      logic [RS_XLEN-1:0]    s2_data;
      logic [RS_XLEN-1:0]    imm;
   } rs_entry_t;

   function automatic logic op_uses_s1(input logic [6:0] op);
      return (op == OP_IMM) || (op == OP_REG) || (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic op_uses_s2(input logic [6:0] op);
      return (op == OP_REG) || (op == OP_STORE);
   endfunction

   function automatic logic op_is_mem(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/rs_dispatch_queue_pick.sv
// pick_lowest: priority encoder selecting the lowest set request bit.
// Ports:
//   req    - request vector
//   onehot - one-hot of the lowest set bit, zero when none
//   idx    - binary index of the lowest set bit, zero when none
//   found  - at least one request bit set
module pick_lowest #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Scan from the top so the last hit, the lowest index, wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IW'(i);
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rs_dispatch_queue.sv
// rs_dispatch_queue: reservation-station dispatch queue.
// Accepts up to WIDTH renamed instructions per cycle into internal RS
// entries. It captures operands from the register file and the CDB, and
// it issues one ready entry per FU with a valid/ready handshake.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   flush                - synchronous squash of all entries
//   disp_*               - per-lane dispatch fields (packed by lane)
//   disp_ready           - all lanes may dispatch this cycle
//   cdb_valid/tag/data   - result broadcast ports (packed by port)
//   iss_valid/iss_ready  - per-FU issue handshake
//   iss_*                - per-FU issued entry fields (packed by FU)
//   free_cnt             - number of free RS entries
module rs_dispatch_queue
   import rs_dispatch_queue_pkg::*;
#(
   parameter int WIDTH    = 2,
   parameter int RS_DEPTH = 16,
   parameter int NUM_FU   = MEM_FU + 1,
   parameter int CDB_N    = 2,
   parameter int PREG_W   = RS_PREG_W,
   parameter int ROB_W    = RS_ROB_W,
   parameter int XLEN     = RS_XLEN
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic [WIDTH-1:0]            disp_valid,
   output logic                        disp_ready,
   input  logic [WIDTH*7-1:0]          disp_op,
   input  logic [WIDTH*PREG_W-1:0]     disp_ps1,
   input  logic [WIDTH*PREG_W-1:0]     disp_ps2,
   input  logic [WIDTH*PREG_W-1:0]     disp_pd,
   input  logic [WIDTH*XLEN-1:0]       disp_imm,
   input  logic [WIDTH*ROB_W-1:0]      disp_rob,
   input  logic [WIDTH-1:0]            disp_s1_rdy,
   input  logic [WIDTH-1:0]            disp_s2_rdy,
   input  logic [WIDTH*XLEN-1:0]       disp_s1_data,
   input  logic [WIDTH*XLEN-1:0]       disp_s2_data,
   input  logic [CDB_N-1:0]            cdb_valid,
   input  logic [CDB_N*PREG_W-1:0]     cdb_tag,
   input  logic [CDB_N*XLEN-1:0]       cdb_data,
   output logic [NUM_FU-1:0]           iss_valid,
   input  logic [NUM_FU-1:0]           iss_ready,
   output logic [NUM_FU*7-1:0]         iss_op,
   output logic [NUM_FU*PREG_W-1:0]    iss_pd,
   output logic [NUM_FU*ROB_W-1:0]     iss_rob,
   output logic [NUM_FU*XLEN-1:0]      iss_src1,
   output logic [NUM_FU*XLEN-1:0]      iss_src2,
   output logic [NUM_FU*XLEN-1:0]      iss_imm,
   output logic [$clog2(RS_DEPTH+1)-1:0] free_cnt
);

   localparam int CNT_W   = $clog2(RS_DEPTH + 1);
   localparam int IDX_W   = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
   localparam int NUM_ALU = NUM_FU - 1;
   localparam logic [RS_FU_W-1:0] MEM_FU_ID = RS_FU_W'(NUM_FU - 1);

   rs_entry_t          ent     [RS_DEPTH];
   rs_entry_t          ent_nxt [RS_DEPTH];
   logic [RS_FU_W-1:0] alu_ptr;
   logic [RS_FU_W-1:0] ptr_nxt;
   logic [CNT_W-1:0]   free_q;
   logic [NUM_FU-1:0]  hold_vld;
   logic [IDX_W-1:0]   hold_idx [NUM_FU];

   logic [RS_DEPTH-1:0] free_vec;
   logic [WIDTH-1:0]    lane_acc;
   logic [WIDTH-1:0]    lane_wr;
   logic [RS_DEPTH-1:0] lane_oh  [WIDTH];
   logic [RS_FU_W-1:0]  lane_fu  [WIDTH];
   rs_entry_t           lane_ent [WIDTH];

   logic [NUM_FU-1:0]   iss_fire;
   logic [IDX_W-1:0]    sel_idx [NUM_FU];
   logic [RS_DEPTH-1:0] fu_clr  [NUM_FU];
   logic [RS_DEPTH-1:0] iss_clr;
   logic [CNT_W-1:0]    n_iss;
   logic [CNT_W-1:0]    n_alloc;

   function automatic logic [RS_FU_W-1:0] alu_next(input logic [RS_FU_W-1:0] p);
      return (p == RS_FU_W'(NUM_ALU - 1)) ? '0 : p + RS_FU_W'(1);
   endfunction

   always_comb begin
      for (int e = 0; e < RS_DEPTH; e++) free_vec[e] = !ent[e].valid;
   end

   // Acceptance uses only the count registered at the start of the cycle,
   // so entries that issue this cycle cannot be reallocated in the same cycle.
   assign disp_ready = (free_q >= CNT_W'(WIDTH));
   assign free_cnt   = free_q;

   // ALU lanes take successive pointer values in lane order.
   always_comb begin
      ptr_nxt = alu_ptr;
      for (int i = 0; i < WIDTH; i++) begin
         lane_fu[i] = MEM_FU_ID;
         if (!op_is_mem(disp_op[i*7 +: 7])) begin
            lane_fu[i] = ptr_nxt;
            if (lane_acc[i]) ptr_nxt = alu_next(ptr_nxt);
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic [RS_DEPTH-1:0] mask_in;
      logic [RS_DEPTH-1:0] mask_out;
      logic [RS_DEPTH-1:0] oh;
      logic [IDX_W-1:0]    idx;
      logic                found;
      logic [6:0]          op;
      logic [PREG_W-1:0]   ps1;
      logic [PREG_W-1:0]   ps2;
      rs_entry_t           new_ent;

      // Each lane searches the free entries left over by lower lanes.
      if (i == 0) begin : g_first
         assign mask_in = free_vec;
      end else begin : g_chain
         assign mask_in = g_lane[i-1].mask_out;
      end

      pick_lowest #(.N(RS_DEPTH), .IW(IDX_W)) u_alloc (
         .req    (mask_in),
         .onehot (oh),
         .idx    (idx),
         .found  (found)
      );

      assign lane_acc[i] = disp_valid[i] && disp_ready && !flush;
      assign lane_wr[i]  = lane_acc[i] && found;
      assign mask_out    = lane_acc[i] ? (mask_in & ~oh) : mask_in;
      assign lane_oh[i]  = oh;
      assign op          = disp_op[i*7 +: 7];
      assign ps1         = disp_ps1[i*PREG_W +: PREG_W];
      assign ps2         = disp_ps2[i*PREG_W +: PREG_W];

      // A same-cycle CDB hit overrides the register-file value; the
      // descending scan lets the lowest matching port win.
      always_comb begin
         new_ent         = '0;
         new_ent.valid   = 1'b1;
         new_ent.op      = op;
         new_ent.fu      = lane_fu[i];
         new_ent.pd      = disp_pd[i*PREG_W +: PREG_W];
         new_ent.rob     = disp_rob[i*ROB_W +: ROB_W];
         new_ent.imm     = disp_imm[i*XLEN +: XLEN];
         new_ent.s1_tag  = ps1;
         new_ent.s2_tag  = ps2;
         new_ent.s1_rdy  = 1'b1;
         new_ent.s2_rdy  = 1'b1;
         if (op_uses_s1(op)) begin
            new_ent.s1_rdy  = disp_s1_rdy[i];
            new_ent.s1_data = disp_s1_data[i*XLEN +: XLEN];
            for (int c = CDB_N - 1; c >= 0; c--) begin
               if (cdb_valid[c] && (cdb_tag[c*PREG_W +: PREG_W] == ps1)) begin
                  new_ent.s1_rdy  = 1'b1;
                  new_ent.s1_data = cdb_data[c*XLEN +: XLEN];
               end
            end
         end
         if (op_uses_s2(op)) begin
            new_ent.s2_rdy  = disp_s2_rdy[i];
            new_ent.s2_data = disp_s2_data[i*XLEN +: XLEN];
            for (int c = CDB_N - 1; c >= 0; c--) begin
               if (cdb_valid[c] && (cdb_tag[c*PREG_W +: PREG_W] == ps2)) begin
                  new_ent.s2_rdy  = 1'b1;
                  new_ent.s2_data = cdb_data[c*XLEN +: XLEN];
               end
            end
         end
      end

      assign lane_ent[i] = new_ent;
   end

   for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
      logic [RS_DEPTH-1:0] req;
      logic [RS_DEPTH-1:0] pick_oh;
      logic [IDX_W-1:0]    pick_idx;
      logic                pick_found;
      logic [RS_DEPTH-1:0] sel_oh;
      rs_entry_t           sel;

      always_comb begin
         for (int e = 0; e < RS_DEPTH; e++) begin
            req[e] = ent[e].valid && (ent[e].fu == RS_FU_W'(f)) &&
                     ent[e].s1_rdy && ent[e].s2_rdy;
         end
      end

      pick_lowest #(.N(RS_DEPTH), .IW(IDX_W)) u_issue (
         .req    (req),
         .onehot (pick_oh),
         .idx    (pick_idx),
         .found  (pick_found)
      );

      // A stalled offer stays locked to its entry so that a lower-index
      // entry waking up cannot change the fields under the FU.
      assign sel_idx[f]   = hold_vld[f] ? hold_idx[f] : pick_idx;
      assign sel_oh       = hold_vld[f] ? (RS_DEPTH'(1) << hold_idx[f]) : pick_oh;
      assign iss_valid[f] = hold_vld[f] || pick_found;
      assign iss_fire[f]  = iss_valid[f] && iss_ready[f] && !flush;
      assign fu_clr[f]    = iss_fire[f] ? sel_oh : '0;
      assign sel          = ent[sel_idx[f]];

      assign iss_op[f*7 +: 7]           = iss_valid[f] ? sel.op      : '0;
      assign iss_pd[f*PREG_W +: PREG_W] = iss_valid[f] ? sel.pd      : '0;
      assign iss_rob[f*ROB_W +: ROB_W]  = iss_valid[f] ? sel.rob     : '0;
      assign iss_src1[f*XLEN +: XLEN]   = iss_valid[f] ? sel.s1_data : '0;
      assign iss_src2[f*XLEN +: XLEN]   = iss_valid[f] ? sel.s2_data : '0;
      assign iss_imm[f*XLEN +: XLEN]    = iss_valid[f] ? sel.imm     : '0;
   end

   always_comb begin
      iss_clr = '0;
      n_iss   = '0;
      n_alloc = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         iss_clr = iss_clr | fu_clr[f];
         n_iss   = n_iss + CNT_W'(iss_fire[f]);
      end
      for (int i = 0; i < WIDTH; i++) n_alloc = n_alloc + CNT_W'(lane_wr[i]);
   end

   // Wakeup, then issue clear, then allocation. Allocated entries were free
   // at the start of the cycle, so they never collide with an issuing entry.
   always_comb begin
      for (int e = 0; e < RS_DEPTH; e++) begin
         ent_nxt[e] = ent[e];
         if (ent[e].valid && !ent[e].s1_rdy) begin
            for (int c = CDB_N - 1; c >= 0; c--) begin
               if (cdb_valid[c] && (cdb_tag[c*PREG_W +: PREG_W] == ent[e].s1_tag)) begin
                  ent_nxt[e].s1_rdy  = 1'b1;
                  ent_nxt[e].s1_data = cdb_data[c*XLEN +: XLEN];
               end
            end
         end
         if (ent[e].valid && !ent[e].s2_rdy) begin
            for (int c = CDB_N - 1; c >= 0; c--) begin
               if (cdb_valid[c] && (cdb_tag[c*PREG_W +: PREG_W] == ent[e].s2_tag)) begin
                  ent_nxt[e].s2_rdy  = 1'b1;
                  ent_nxt[e].s2_data = cdb_data[c*XLEN +: XLEN];
               end
            end
         end
         if (iss_clr[e]) ent_nxt[e].valid = 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            if (lane_wr[i] && lane_oh[i][e]) ent_nxt[e] = lane_ent[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < RS_DEPTH; e++) ent[e] <= '0;
         for (int f = 0; f < NUM_FU; f++) hold_idx[f] <= '0;
         alu_ptr  <= '0;
         free_q   <= CNT_W'(RS_DEPTH);
         hold_vld <= '0;
      end else if (flush) begin
         for (int e = 0; e < RS_DEPTH; e++) ent[e] <= '0;
         for (int f = 0; f < NUM_FU; f++) hold_idx[f] <= '0;
         alu_ptr  <= '0;
         free_q   <= CNT_W'(RS_DEPTH);
         hold_vld <= '0;
      end else begin
         for (int e = 0; e < RS_DEPTH; e++) ent[e] <= ent_nxt[e];
         for (int f = 0; f < NUM_FU; f++) hold_idx[f] <= sel_idx[f];
         alu_ptr  <= ptr_nxt;
         free_q   <= free_q + n_iss - n_alloc;
         hold_vld <= iss_valid & ~iss_ready;
      end
   end

endmodule

// File: doc/rs_dispatch_queue.md
Name: rs_dispatch_queue

Overview:
- Parametrised, clocked successor to the combinational dispatch stage.
- Accepts up to WIDTH renamed instructions per cycle and allocates reservation-station (RS) entries it owns internally.
- Captures operands from the register file and the common data bus (CDB), then issues one ready entry per functional unit (FU) per cycle with a valid/ready handshake.
- Sits between rename and the FUs/ROB.

Parameters:
- WIDTH, 2, dispatch lanes per cycle
- RS_DEPTH, 16, RS entries
- NUM_FU, 3, FUs; FU NUM_FU-1 is memory-only, FUs 0..NUM_FU-2 are ALU (NUM_FU >= 2)
- CDB_N, 2, CDB broadcast ports
- PREG_W, 6, physical tag width
- ROB_W, 4, ROB index width
- XLEN, 32, data width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all entries
- disp_valid  in  WIDTH  per-lane instruction valid
- disp_ready  out  1  all lanes may dispatch this cycle
- disp_op  in  WIDTH*7  opcode per lane
- disp_ps1, disp_ps2, disp_pd  in  WIDTH*PREG_W  source/destination physical tags
- disp_imm  in  WIDTH*XLEN  immediate, already extended by decode
- disp_rob  in  WIDTH*ROB_W  ROB index from the ROB allocator
- disp_s1_rdy, disp_s2_rdy  in  WIDTH  register-file ready bits
- disp_s1_data, disp_s2_data  in  WIDTH*XLEN  register-file data
- cdb_valid  in  CDB_N  broadcast valid
- cdb_tag  in  CDB_N*PREG_W  broadcast tag
- cdb_data  in  CDB_N*XLEN  broadcast data
- iss_valid  out  NUM_FU  issue valid per FU
- iss_ready  in  NUM_FU  FU accepts
- iss_op, iss_pd, iss_rob, iss_src1, iss_src2, iss_imm  out  per-FU packed  issued entry fields
- free_cnt  out  $clog2(RS_DEPTH+1)  free entries

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All entries invalid; round-robin ALU pointer = 0.
  - iss_valid = 0; free_cnt = RS_DEPTH; disp_ready = 1 once reset is released.
- Dispatch acceptance:
  - disp_ready = (free_cnt >= WIDTH). It is all-or-nothing, independent of disp_valid, and does not count entries freed this cycle.
  - Lane i is accepted when disp_valid[i] && disp_ready && !flush.
- Allocation:
  - Accepted lanes take the lowest-index free entries in lane order; lane 0 gets the lowest.
  - Invalid lanes consume no entry. Two lanes never receive the same entry.
- Operand usage by opcode:
  - 0010011: src1 from register; src2 unused (ready, 0).
  - 0110011: src1 and src2 from register.
  - 0000011: src1 from register.
  - 0100011: src1 and src2 from register.
  - Other opcodes: both sources marked ready with data 0.
  - imm is stored for every entry.
- Operand capture at dispatch: source ready = disp_sX_rdy OR any same-cycle CDB tag match. A CDB match overrides the register-file data.
- FU binding at dispatch:
  - Opcodes 0000011/0100011 go to FU NUM_FU-1.
  - All other opcodes take the round-robin ALU pointer, which then advances modulo NUM_FU-1.
  - Multiple accepted ALU lanes in one cycle take successive pointer values.
  - The pointer persists across cycles and is unchanged by invalid or memory lanes.
- Wakeup: a waiting entry whose src tag matches a valid CDB tag captures the data and sets ready at the clock edge. The lowest CDB port wins if several match.
- Issue select:
  - Combinational from registered state.
  - Per FU, pick the lowest-index valid entry bound to that FU with both sources ready.
  - The entry is freed at the edge where iss_valid && iss_ready.
  - iss_* outputs are held stable while iss_valid && !iss_ready.
- Latency:
  - An entry dispatched with ready operands issues at the earliest in the next cycle.
  - A CDB wakeup leads to issue at the earliest in the next cycle.
- Simultaneous free and allocate of the same index in one cycle cannot occur, because allocation only sees entries free at the start of the cycle.
- free_cnt is updated at the edge: plus issues, minus allocations.
- flush:
  - At the edge, all entries are invalidated and the pointer is reset to 0.
  - The same-cycle dispatch is dropped; issue handshakes in that cycle are ignored.
  - free_cnt = RS_DEPTH next cycle.
- Full: with free_cnt < WIDTH, disp_ready = 0, even if only one lane is valid.

Decomposition:
- Shared package: opcode constants (OP_IMM, OP_REG, OP_LOAD, OP_STORE), rs_entry_t struct, MEM_FU constant.
- Sub-module: pick_lowest (parametrised priority encoder returning one-hot and index). It is reused for free-entry search, per-lane allocation with masking, and per-FU issue select.

Test Plan:
- Reset, then dispatch lane0 ADDI ps1=5 rdy imm=7 plus lane1 ADD ps1=3 ps2=4 both rdy -> entries 0/1; FU0/FU1 iss_valid next cycle; free_cnt=14 then 16 after both accept.
- ADD with ps2=9 not ready; CDB tag 9 data 0x55 two cycles later -> iss_valid rises the cycle after the broadcast with iss_src2=0x55.
- Same-cycle bypass: dispatch ps1=12 not ready while cdb_tag=12 data 0xAA -> entry issues next cycle with src1=0xAA.
- Fill: dispatch 7 pairs with no readiness and iss_ready=0 -> free_cnt=2, disp_ready=1; 8th pair -> free_cnt=0, disp_ready=0; one issue -> free_cnt=1, disp_ready stays 0.
- Mixed: LW, ADD, ADD, SW across two cycles -> FU bindings 2,0,1,2; the pointer continues to 0 for the next ALU op.
- Backpressure and flush: iss_valid held with iss_ready=0 for 3 cycles -> fields stable; flush asserted with disp_valid=11 -> all iss_valid=0 next cycle, free_cnt=16.
